// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SaDefaultWidth = 8;

  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

  localparam int unsigned SaCntWidth = sa_cnt_width(SaDefaultWidth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sa_state_e;

endpackage

// File: rtl/bit_slice_fa.sv
// Combinational one-bit full adder cell.
module bit_slice_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ cin_i;
  assign c_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SaDefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CntW = sa_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  bit_slice_fa u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .cin_i(carry_q),
    .s_o  (fa_s),
    .c_o  (fa_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start too, giving back-to-back operation
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Publish only on the last bit so sum_o never shows partial results
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule
